// File: rtl/bkg_pkg.sv
// Shared types and constants for the background pixel source: palette FSM
// states, the power-on palette and the nominal pipeline latency.
package bkg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } pal_state_t;

  localparam int RAM_LAT_DEFAULT = 1;
  localparam int LAT             = RAM_LAT_DEFAULT + 2;

  function automatic logic [63:0][11:0] build_default_palette();
    logic [63:0][11:0] p;
    for (int i = 0; i < 64; i++) p[i] = 12'hFFF;
    p[0]  = 12'h000;
    p[1]  = 12'hFFF;
    p[2]  = 12'h630;
    p[3]  = 12'h911;
    p[39] = 12'h2A0;
    return p;
  endfunction

  localparam logic [63:0][11:0] DEFAULT_PALETTE = build_default_palette();

endpackage

// File: rtl/bkg_palette.sv
// Double-buffered palette: software writes land in the shadow bank and a
// commit copies the whole shadow bank to the active bank at the next frame.
module bkg_palette
  import bkg_pkg::*;
#(
  parameter int                CODE_W      = 6,
  parameter int                RGB_W       = 12,
  parameter bit                TRANSP_EN   = 1'b1,
  parameter logic [CODE_W-1:0] TRANSP_CODE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CODE_W-1:0] wr_idx,
  input  logic [RGB_W-1:0]  wr_rgb,
  input  logic              commit,
  input  logic              frame_start,
  output logic              pending,
  input  logic              rd_en,
  input  logic [CODE_W-1:0] rd_code,
  output logic [RGB_W-1:0]  rgb,
  output logic              opaque
);

  localparam int DEPTH = 1 << CODE_W;

  typedef logic [DEPTH-1:0][RGB_W-1:0] bank_t;

  function automatic bank_t init_bank();
    bank_t b;
    for (int i = 0; i < DEPTH; i++) begin
      b[i] = (i < 64) ? RGB_W'(DEFAULT_PALETTE[i[5:0]]) : RGB_W'(12'hFFF);
    end
    return b;
  endfunction

  localparam bank_t PAL_INIT = init_bank();

  pal_state_t state;
  bank_t      shadow;
  bank_t      active;

  assign wr_ready = (state == IDLE);
  assign pending  = (state == PEND);

  // A commit seen together with frame_start still waits for the next frame.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (commit) state <= PEND;
        PEND:    if (frame_start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: both banks carry a reset value, so they are built from flops; an
  // inferred RAM cannot be reset to a table and would not match this intent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= PAL_INIT;
      active <= PAL_INIT;
    end else begin
      if (wr_valid && wr_ready) shadow[wr_idx] <= wr_rgb;
      if (state == PEND && frame_start) active <= shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb    <= '0;
      opaque <= 1'b0;
    end else begin
      rgb    <= rd_en ? active[rd_code] : '0;
      opaque <= rd_en && !(TRANSP_EN && (rd_code == TRANSP_CODE));
    end
  end

endmodule

// File: rtl/bkg_pixel_src.sv
// Background pixel source: scrolls the scan position into a background-RAM
// address and colours the returned code through the double-buffered palette.
module bkg_pixel_src
  import bkg_pkg::*;
#(
  parameter int                H_BITS      = 10,
  parameter int                V_BITS      = 10,
  parameter int                CODE_W      = 6,
  parameter int                RGB_W       = 12,
  parameter int                RAM_LAT     = 1,
  parameter bit                TRANSP_EN   = 1'b1,
  parameter logic [CODE_W-1:0] TRANSP_CODE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [10:0]              x,
  input  logic [10:0]              y,
  input  logic                     video_on,
  input  logic                     frame_start,
  input  logic [H_BITS-1:0]        x_off,
  input  logic [V_BITS-1:0]        y_off,
  output logic [H_BITS+V_BITS-1:0] ram_addr,
  input  logic [CODE_W-1:0]        ram_code,
  input  logic                     pal_wr_valid,
  output logic                     pal_wr_ready,
  input  logic [CODE_W-1:0]        pal_wr_idx,
  input  logic [RGB_W-1:0]         pal_wr_rgb,
  input  logic                     pal_commit,
  output logic                     pal_pending,
  output logic [RGB_W-1:0]         rgb,
  output logic                     rgb_opaque
);

  // video_on must line up with ram_code, one stage ahead of the palette lookup.
  localparam int VID_DLY = LAT - 1 + (RAM_LAT - RAM_LAT_DEFAULT);

  logic [H_BITS-1:0]  x_off_q, xo, col;
  logic [V_BITS-1:0]  y_off_q, yo, row;
  logic [VID_DLY-1:0] vid_dly;

  // NOTE: every combinational output is assigned on every path, so no
  // latch can be inferred.
  always_comb begin
    xo  = frame_start ? x_off : x_off_q;
    yo  = frame_start ? y_off : y_off_q;
    col = x[H_BITS-1:0] + xo;
    row = y[V_BITS-1:0] + yo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_off_q  <= '0;
      y_off_q  <= '0;
      ram_addr <= '0;
    end else begin
      if (frame_start) begin
        x_off_q <= x_off;
        y_off_q <= y_off;
      end
      ram_addr <= {row, col};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vid_dly <= '0;
    else        vid_dly <= {vid_dly[VID_DLY-2:0], video_on};
  end

  generate
    if (H_BITS < 11) begin : g_x_unused
      logic unused_x_hi;
      assign unused_x_hi = ^x[10:H_BITS];
    end
    if (V_BITS < 11) begin : g_y_unused
      logic unused_y_hi;
      assign unused_y_hi = ^y[10:V_BITS];
    end
  endgenerate

  bkg_palette #(
    .CODE_W      (CODE_W),
    .RGB_W       (RGB_W),
    .TRANSP_EN   (TRANSP_EN),
    .TRANSP_CODE (TRANSP_CODE)
  ) u_palette (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (pal_wr_valid),
    .wr_ready    (pal_wr_ready),
    .wr_idx      (pal_wr_idx),
    .wr_rgb      (pal_wr_rgb),
    .commit      (pal_commit),
    .frame_start (frame_start),
    .pending     (pal_pending),
    .rd_en       (vid_dly[VID_DLY-1]),
    .rd_code     (ram_code),
    .rgb         (rgb),
    .opaque      (rgb_opaque)
  );

endmodule

// File: tb/tb_bkg_pixel_src.sv
// Self-checking bench for bkg_pixel_src: a cycle-level scoreboard built from
// the pipeline's timing rules plus directed scenario tasks.
module tb_bkg_pixel_src;

  logic        clk;
  logic        rst_n;
  logic [10:0] x, y;
  logic        video_on, frame_start;
  logic [9:0]  x_off, y_off;
  logic [19:0] ram_addr;
  logic [5:0]  ram_code;
  logic        pal_wr_valid, pal_wr_ready;
  logic [5:0]  pal_wr_idx;
  logic [11:0] pal_wr_rgb;
  logic        pal_commit, pal_pending;
  logic [11:0] rgb;
  logic        rgb_opaque;

  int checks = 0;
  int errors = 0;

  bkg_pixel_src dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .video_on     (video_on),
    .frame_start  (frame_start),
    .x_off        (x_off),
    .y_off        (y_off),
    .ram_addr     (ram_addr),
    .ram_code     (ram_code),
    .pal_wr_valid (pal_wr_valid),
    .pal_wr_ready (pal_wr_ready),
    .pal_wr_idx   (pal_wr_idx),
    .pal_wr_rgb   (pal_wr_rgb),
    .pal_commit   (pal_commit),
    .pal_pending  (pal_pending),
    .rgb          (rgb),
    .rgb_opaque   (rgb_opaque)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External background RAM: fixed contents, one cycle of read latency.
  logic [5:0] ram_ovr [int];

  function automatic logic [5:0] ram_fn(input logic [19:0] a);
    if (ram_ovr.exists(int'(a))) return ram_ovr[int'(a)];
    return a[5:0] ^ a[15:10] ^ {2'b00, a[19:16]};
  endfunction

  always @(posedge clk) ram_code <= ram_fn(ram_addr);

  // Reference model state.
  typedef struct packed { logic [5:0] code; logic vid; } pix_t;
  typedef struct packed { logic [11:0] rgb; logic op; } exp_t;

  logic [11:0] m_active [64];
  logic [11:0] m_shadow [64];
  logic        m_pend;
  int          m_xoff, m_yoff;
  exp_t        exp_q [$];
  pix_t        prev;
  logic        prev_valid;

  function automatic logic [11:0] default_rgb(input int i);
    case (i)
      0:       return 12'h000;
      2:       return 12'h630;
      3:       return 12'h911;
      39:      return 12'h2A0;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_active[i] = default_rgb(i);
      m_shadow[i] = default_rgb(i);
    end
    m_pend     = 1'b0;
    m_xoff     = 0;
    m_yoff     = 0;
    prev_valid = 1'b0;
    exp_q.delete();
  endtask

  // One pixel clock: advance the model with the current inputs, clock the
  // DUT, then compare at the falling edge. A pixel entered in cycle t is
  // coloured with the palette as it stands after cycle t+1's events.
  task automatic cycle();
    pix_t        cur;
    exp_t        e;
    int          col, row;
    logic [19:0] a;
    logic        pend_before;
    if (frame_start) begin
      m_xoff = int'(x_off);
      m_yoff = int'(y_off);
    end
    col      = (int'(x[9:0]) + m_xoff) % 1024;
    row      = (int'(y[9:0]) + m_yoff) % 1024;
    a        = {row[9:0], col[9:0]};
    cur.code = ram_fn(a);
    cur.vid  = video_on;
    pend_before = m_pend;
    if (pal_wr_valid && !pend_before) m_shadow[pal_wr_idx] = pal_wr_rgb;
    if (!pend_before && pal_commit) m_pend = 1'b1;
    else if (pend_before && frame_start) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
    if (prev_valid) begin
      e.rgb = prev.vid ? m_active[prev.code] : 12'h000;
      e.op  = prev.vid && (prev.code != 6'd0);
      exp_q.push_back(e);
    end
    prev       = cur;
    prev_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram_addr !== a) begin
      errors++;
      $display("FAIL ram_addr: got %h expected %h", ram_addr, a);
    end
    checks++;
    if (pal_pending !== m_pend || pal_wr_ready !== !m_pend) begin
      errors++;
      $display("FAIL pal_state: got pending=%b ready=%b expected pending=%b", pal_pending, pal_wr_ready, m_pend);
    end
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      checks++;
      if (rgb !== e.rgb || rgb_opaque !== e.op) begin
        errors++;
        $display("FAIL pixel: got rgb=%h op=%b expected rgb=%h op=%b", rgb, rgb_opaque, e.rgb, e.op);
      end
    end
  endtask

  task automatic px(input int xx, input int yy, input logic vid, input logic fs);
    x           = 11'(xx);
    y           = 11'(yy);
    video_on    = vid;
    frame_start = fs;
    cycle();
    frame_start  = 1'b0;
    pal_commit   = 1'b0;
    pal_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x = '0; y = '0; video_on = 1'b0; frame_start = 1'b0;
    x_off = '0; y_off = '0;
    pal_wr_valid = 1'b0; pal_wr_idx = '0; pal_wr_rgb = '0; pal_commit = 1'b0;
    model_reset();
    #22;
    checks++;
    if (rgb !== 12'h000 || rgb_opaque !== 1'b0 || ram_addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rgb=%h op=%b addr=%h expected 000 0 00000", rgb, rgb_opaque, ram_addr);
    end
    checks++;
    if (pal_wr_ready !== 1'b1 || pal_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_palette: got ready=%b pending=%b expected 1 0", pal_wr_ready, pal_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_pixel();
    ram_ovr[int'({10'd7, 10'd5})] = 6'd2;
    px(0, 0, 1'b1, 1'b1);
    px(5, 7, 1'b1, 1'b0);
    checks++;
    if (ram_addr !== {10'd7, 10'd5}) begin
      errors++;
      $display("FAIL default_addr: got %h expected %h", ram_addr, {10'd7, 10'd5});
    end
    px(6, 7, 1'b1, 1'b0);
    px(7, 7, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h630 || rgb_opaque !== 1'b1) begin
      errors++;
      $display("FAIL default_pixel: got rgb=%h op=%b expected 630 1", rgb, rgb_opaque);
    end
  endtask

  task automatic test_scroll_wrap();
    x_off = 10'd1023;
    y_off = 10'd1;
    px(0, 0, 1'b1, 1'b1);
    x_off = 10'($urandom);
    y_off = 10'($urandom);
    px(1, 0, 1'b1, 1'b0);
    checks++;
    if (ram_addr !== {10'd1, 10'd0}) begin
      errors++;
      $display("FAIL scroll_wrap: got %h expected %h", ram_addr, {10'd1, 10'd0});
    end
    for (int i = 0; i < 8; i++) px(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b1, 1'b0);
    x_off = '0;
    y_off = '0;
    px(0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_palette_update();
    checks++;
    if (pal_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_idle: got %b expected 1", pal_wr_ready);
    end
    pal_wr_valid = 1'b1; pal_wr_idx = 6'd2; pal_wr_rgb = 12'h0F0;
    px(5, 7, 1'b1, 1'b0);
    pal_commit = 1'b1;
    px(5, 7, 1'b1, 1'b0);
    checks++;
    if (pal_pending !== 1'b1 || pal_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending_after_commit: got pending=%b ready=%b expected 1 0", pal_pending, pal_wr_ready);
    end
    pal_commit = 1'b1;
    px(5, 7, 1'b1, 1'b0);
    px(5, 7, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h630) begin
      errors++;
      $display("FAIL old_palette_held: got %h expected 630", rgb);
    end
    px(0, 0, 1'b1, 1'b1);
    px(5, 7, 1'b1, 1'b0);
    px(1, 0, 1'b1, 1'b0);
    px(2, 0, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h0F0 || pal_pending !== 1'b0) begin
      errors++;
      $display("FAIL new_palette: got rgb=%h pending=%b expected 0f0 0", rgb, pal_pending);
    end
  endtask

  task automatic test_commit_at_frame_start();
    ram_ovr[int'({10'd7, 10'd6})] = 6'd3;
    pal_wr_valid = 1'b1; pal_wr_idx = 6'd3; pal_wr_rgb = 12'hABC;
    pal_commit = 1'b1;
    px(0, 0, 1'b1, 1'b1);
    checks++;
    if (pal_pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_same_frame_pending: got %b expected 1", pal_pending);
    end
    px(6, 7, 1'b1, 1'b0);
    px(1, 0, 1'b1, 1'b0);
    px(2, 0, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h911) begin
      errors++;
      $display("FAIL no_swap_same_frame: got %h expected 911", rgb);
    end
    px(0, 0, 1'b1, 1'b1);
    px(6, 7, 1'b1, 1'b0);
    px(1, 0, 1'b1, 1'b0);
    px(2, 0, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'hABC) begin
      errors++;
      $display("FAIL swap_next_frame: got %h expected abc", rgb);
    end
  endtask

  task automatic test_transparency();
    ram_ovr[int'({10'd7, 10'd8})] = 6'd0;
    ram_ovr[int'({10'd7, 10'd9})] = 6'd1;
    px(8, 7, 1'b1, 1'b0);
    px(9, 7, 1'b0, 1'b0);
    px(1, 1, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h000 || rgb_opaque !== 1'b0) begin
      errors++;
      $display("FAIL transparent_code: got rgb=%h op=%b expected 000 0", rgb, rgb_opaque);
    end
    px(2, 1, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h000 || rgb_opaque !== 1'b0) begin
      errors++;
      $display("FAIL blanked_pixel: got rgb=%h op=%b expected 000 0", rgb, rgb_opaque);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pal_wr_valid = 1'b1;
        pal_wr_idx   = 6'($urandom);
        pal_wr_rgb   = 12'($urandom);
      end
      pal_commit = ($urandom_range(0, 29) == 0);
      x_off = 10'($urandom);
      y_off = 10'($urandom);
      px(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
         1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end
  endtask

  task automatic test_reset_pending();
    pal_wr_valid = 1'b1; pal_wr_idx = 6'd2; pal_wr_rgb = 12'h555;
    pal_commit = 1'b1;
    px(5, 7, 1'b1, 1'b0);
    checks++;
    if (pal_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_before_reset: got %b expected 1", pal_pending);
    end
    pal_wr_valid = 1'b1; pal_wr_idx = 6'd2; pal_wr_rgb = 12'h777;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pal_pending !== 1'b0 || pal_wr_ready !== 1'b1 || rgb !== 12'h000) begin
      errors++;
      $display("FAIL reset_abort: got pending=%b ready=%b rgb=%h expected 0 1 000", pal_pending, pal_wr_ready, rgb);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pal_wr_valid = 1'b0;
    x_off = '0;
    y_off = '0;
    px(0, 0, 1'b1, 1'b1);
    px(5, 7, 1'b1, 1'b0);
    px(1, 0, 1'b1, 1'b0);
    px(2, 0, 1'b1, 1'b0);
    checks++;
    if (rgb !== 12'h630 || pal_pending !== 1'b0) begin
      errors++;
      $display("FAIL palette_after_reset: got rgb=%h pending=%b expected 630 0", rgb, pal_pending);
    end
  endtask

  initial begin
    test_reset();
    test_default_pixel();
    test_scroll_wrap();
    test_palette_update();
    test_commit_at_frame_start();
    test_transparency();
    test_random();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
